credit_bp_tx: RTL and testbench

Credit-based backpressure transmitter: the sending end of the credit link whose receiving end is a `fifo32` buffer. It accepts flits from an upstream valid/ready source and pushes them onto the link only while it holds credits. It reclaims one credit per pop pulse returned by the receiver. This guarantees the receiver FIFO (capacity `DEPTH32*32-1`) never overflows, with no ready signal on the link.

---
 rtl/credit_bp_tx.sv | 94 +++++++++
 tb/tb_credit_bp_tx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/credit_bp_tx.sv
// rtl/credit_bp_tx.sv - credit-based backpressure link transmitter; optional overflow checker under CREDIT_BP_TX_OVERFLOW_CHECK_EN
module credit_bp_tx #(
    parameter int DEPTH32 = 4,
    parameter int WIDTH   = 32,
    localparam int CMAX   = DEPTH32 * 32 - 1,
    localparam int CW     = $clog2(CMAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_push,
    output logic [WIDTH-1:0] o_wdata,
    input  logic             i_credit,
    output logic [CW-1:0]    o_credits,
    output logic             o_idle,
    output logic             o_credit_err
);

    localparam logic [CW-1:0] CMAX_C = CW'(CMAX);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             accept;
    logic             at_max;
    logic             push_q;
    logic [WIDTH-1:0] wdata_q;

    // ready is decoded from the registered count only, so no input can reach it combinationally
    assign o_ready   = (cnt != '0);
    assign accept    = i_valid && o_ready;
    assign at_max    = (cnt == CMAX_C);
    assign o_credits = cnt;
    assign o_push    = push_q;
    assign o_wdata   = wdata_q;
    assign o_idle    = at_max && !push_q;

    // next credit count: spend one per accept, reclaim one per returned credit, saturate at CMAX
    always_comb begin
        cnt_nxt = cnt;
        if (accept && !i_credit) begin
            cnt_nxt = cnt - ONE_C;
        end else if (!accept && i_credit && !at_max) begin
            cnt_nxt = cnt + ONE_C;
        end
    end

    // credit counter register; reset restores a full budget since the receiver restarts empty
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= CMAX_C;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // single link output register; data holds between pushes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            push_q  <= 1'b0;
            wdata_q <= '0;
        end else begin
            push_q <= accept;
            if (accept) begin
                wdata_q <= i_data;
            end
        end
    end

`ifdef CREDIT_BP_TX_OVERFLOW_CHECK_EN
    logic overflow;
    logic err_q;

    assign overflow     = i_credit && at_max && !accept;
    assign o_credit_err = err_q;

    // sticky record of a credit returned while the budget was already full
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (overflow) begin
            err_q <= 1'b1;
`ifndef SYNTHESIS
            $error("credit_bp_tx: credit returned while holding all CMAX credits");
`endif
        end
    end
`else
    assign o_credit_err = 1'b0;
`endif

endmodule

// File: tb/tb_credit_bp_tx.sv
// tb/tb_credit_bp_tx.sv - self-checking bench for credit_bp_tx with scoreboard and receiver model
module tb_credit_bp_tx;

    localparam int CMAX = 127;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic [31:0] i_data;
    logic        o_ready;
    logic        o_push;
    logic [31:0] o_wdata;
    logic        i_credit;
    logic [6:0]  o_credits;
    logic        o_idle;
    logic        o_credit_err;

    credit_bp_tx #(.DEPTH32(4), .WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .o_ready      (o_ready),
        .o_push       (o_push),
        .o_wdata      (o_wdata),
        .i_credit     (i_credit),
        .o_credits    (o_credits),
        .o_idle       (o_idle),
        .o_credit_err (o_credit_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int mcnt;
    logic merr;
    logic [31:0] exp_q[$];
    int npush;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        c;
        logic        exp_push;
        logic [31:0] exp_wdata;
        logic [6:0]  exp_cred;
        logic        exp_idle;
    } vec_t;

    vec_t vecs[5];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_credit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mcnt = CMAX; merr = 1'b0; exp_q.delete();
    endtask

    // drive one cycle, advance the reference model, then check all outputs after the edge
    task automatic step(input logic v, input logic [31:0] d, input logic c);
        logic acc;
        i_valid = v; i_data = d; i_credit = c;
        acc = v && (mcnt != 0);
        if (acc) exp_q.push_back(d);
`ifdef CREDIT_BP_TX_OVERFLOW_CHECK_EN
        if (c && mcnt == CMAX && !acc) merr = 1'b1;
`endif
        if (acc && !c) mcnt--;
        else if (!acc && c && mcnt < CMAX) mcnt++;
        @(posedge clk);
        #1;
        chk("push", o_push, acc);
        if (o_push) begin
            npush++;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL wdata: push with got %0h but nothing expected", o_wdata);
            end else begin
                chk("wdata", o_wdata, exp_q.pop_front());
            end
        end
        chk("credits", o_credits, mcnt);
        chk("ready", o_ready, mcnt != 0);
        chk("idle", o_idle, (mcnt == CMAX) && !acc);
        chk("err", o_credit_err, merr);
    endtask

    initial begin
        logic [31:0] rx_q[$];
        logic [31:0] sent[$];
        logic [31:0] d;
        logic v, c, hold;
        int rx_idx, guard;

        vecs[0] = '{1'b1, 32'hA5A5A5A5, 1'b0, 1'b1, 32'hA5A5A5A5, 7'd126, 1'b0};
        vecs[1] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 32'hA5A5A5A5, 7'd127, 1'b1};
        vecs[2] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 32'hA5A5A5A5, 7'd127, 1'b1};
        vecs[3] = '{1'b1, 32'h12345678, 1'b1, 1'b1, 32'h12345678, 7'd127, 1'b0};
        vecs[4] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 32'h12345678, 7'd127, 1'b1};

        // reset values
        do_reset();
        chk("rst_credits", o_credits, 7'd127);
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_push", o_push, 1'b0);
        chk("rst_wdata", o_wdata, 32'h0);
        chk("rst_idle", o_idle, 1'b1);
        chk("rst_err", o_credit_err, 1'b0);

        // single flit, credit return, overflow, accept+credit at full budget
        for (int i = 0; i < 5; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].c);
            chk("tbl_push", o_push, vecs[i].exp_push);
            chk("tbl_wdata", o_wdata, vecs[i].exp_wdata);
            chk("tbl_credits", o_credits, vecs[i].exp_cred);
            chk("tbl_idle", o_idle, vecs[i].exp_idle);
`ifdef CREDIT_BP_TX_OVERFLOW_CHECK_EN
            chk("tbl_err", o_credit_err, i >= 2);
`else
            chk("tbl_err", o_credit_err, 1'b0);
`endif
        end

        // credit exhaustion
        do_reset();
        npush = 0;
        for (int ii = 0; ii < 127; ii++) step(1'b1, ii * 123, 1'b0);
        chk("exh_ready_after_127", o_ready, 1'b0);
        for (int ii = 127; ii < 130; ii++) step(1'b1, 32'd127 * 123, 1'b0);
        chk("exh_accepts", npush, 127);
        chk("exh_credits", o_credits, 7'd0);
        chk("exh_ready", o_ready, 1'b0);
        npush = 0;
        step(1'b1, 32'd127 * 123, 1'b1);
        chk("exh_ready_back", o_ready, 1'b1);
        step(1'b1, 32'd127 * 123, 1'b0);
        chk("exh_one_more_wdata", o_wdata, 32'd127 * 123);
        step(1'b1, 32'd128 * 123, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        chk("exh_one_more_count", npush, 1);

        // simultaneous accept and credit at 50
        do_reset();
        for (int i = 0; i < 77; i++) step(1'b1, 32'hC000_0000 + i, 1'b0);
        chk("sim_start", o_credits, 7'd50);
        npush = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'hD000_0000 + i, 1'b1);
            chk("sim_hold", o_credits, 7'd50);
        end
        chk("sim_pushes", npush, 10);
        step(1'b0, 32'd0, 1'b0);

        // end-to-end with a FWFT receiver model popping whenever non-empty
        do_reset();
        rx_idx = 0; hold = 1'b0; d = '0; v = 1'b0;
        guard = 0;
        while ((sent.size() < 1000 || rx_q.size() != 0 || mcnt != CMAX || o_push) && guard < 5000) begin
            guard++;
            c = (rx_q.size() != 0);
            if (c) begin
                logic [31:0] got;
                got = rx_q.pop_front();
                chk("e2e_order", got, sent[rx_idx]);
                rx_idx++;
            end
            if (!hold) begin
                v = (sent.size() < 1000) && ($urandom_range(0, 3) != 0);
                d = $urandom;
            end
            hold = v && (mcnt == 0);
            if (v && mcnt != 0) sent.push_back(d);
            step(v, d, c);
            if (o_push) begin
                if (rx_q.size() >= CMAX) begin
                    total++; bad++;
                    $display("FAIL e2e_full: push with receiver occupancy %0d limit %0d", rx_q.size(), CMAX);
                end
                rx_q.push_back(o_wdata);
            end
        end
        chk("e2e_done", guard < 5000, 1'b1);
        chk("e2e_count", rx_idx, 1000);
        chk("e2e_final_credits", o_credits, 7'd127);
        chk("e2e_final_idle", o_idle, 1'b1);

        // overflow at full credits, then reset clears the flag
        step(1'b0, 32'd0, 1'b1);
        chk("ovf_credits", o_credits, 7'd127);
`ifdef CREDIT_BP_TX_OVERFLOW_CHECK_EN
        chk("ovf_err", o_credit_err, 1'b1);
        step(1'b0, 32'd0, 1'b0);
        chk("ovf_sticky", o_credit_err, 1'b1);
`else
        chk("ovf_err", o_credit_err, 1'b0);
`endif
        do_reset();
        chk("ovf_rst_err", o_credit_err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
